// File: rtl/ddr_axi_pkg.sv
// ddr_axi_pkg: shared types and constants for the DDR AXI burst master.
package ddr_axi_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AW   = 3'd1,
    ST_W    = 3'd2,
    ST_B    = 3'd3,
    ST_AR   = 3'd4,
    ST_R    = 3'd5,
    ST_RSP  = 3'd6
  } burst_state_t;

  localparam int         BURST_LEN   = 4;
  localparam logic [3:0] AXLEN_FIXED = 4'd3;

  // Any response other than OKAY (EXOKAY included) is an error for this master.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != OKAY;
  endfunction

endpackage

// File: rtl/ddr_axi_wdog.sv
// ddr_axi_wdog: per-phase watchdog for the burst master. Counts cycles while the
// master waits on the bus; any handshake or leaving the bus phases clears it.
module ddr_axi_wdog
  import ddr_axi_pkg::*;
#(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic active_i,
  input  logic kick_i,
  output logic expired_o
);
  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q;

  // Cycle counter: cleared by reset, idle phases and handshakes; saturates at expiry
  always_ff @(posedge clk_i) begin
    if (rst_i || !active_i || kick_i) begin
      cnt_q <= '0;
    end else if (!expired_o) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

  // Expiry fires in the LIMIT-th waiting cycle so the FSM leaves after exactly LIMIT cycles.
  assign expired_o = active_i && (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/ddr_axi_burst_master.sv
// ddr_axi_burst_master: single-outstanding AXI initiator issuing fixed 4-beat INCR
// bursts (AW/W/B or AR/R) and returning one completion per command.
// Build macro AXI_MASTER_TIMEOUT_EN adds the ddr_axi_wdog watchdog (TIMEOUT_CYCLES).
module ddr_axi_burst_master
  import ddr_axi_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [4*DATA_W-1:0]   cmd_wdata,
  input  logic [3:0]            cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [4*DATA_W-1:0]   rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_W-1:0]     M0_AWADDR,
  output logic [3:0]            M0_AWLEN,
  output logic                  M0_AWVALID,
  input  logic                  M0_AWREADY,
  output logic [DATA_W-1:0]     M0_WDATA,
  output logic [3:0]            M0_WSTRB,
  output logic                  M0_WLAST,
  output logic                  M0_WVALID,
  input  logic                  M0_WREADY,
  input  logic [1:0]            M0_BRESP,
  input  logic                  M0_BVALID,
  output logic                  M0_BREADY,
  output logic [ADDR_W-1:0]     M0_ARADDR,
  output logic [3:0]            M0_ARLEN,
  output logic                  M0_ARVALID,
  input  logic                  M0_ARREADY,
  input  logic [DATA_W-1:0]     M0_RDATA,
  input  logic [1:0]            M0_RRESP,
  input  logic                  M0_RVALID,
  input  logic                  M0_RLAST,
  output logic                  M0_RREADY
);
  localparam logic [1:0]        LAST_BEAT = 2'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] ADDR_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  burst_state_t        state_q;
  logic [1:0]          beat_q;
  logic [4*DATA_W-1:0] wbuf_q;
  logic                cmd_ready_q, rsp_valid_q, rsp_write_q, rsp_err_q;
  logic [4*DATA_W-1:0] rsp_rdata_q;
  logic [ADDR_W-1:0]   awaddr_q, araddr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [3:0]          wstrb_q;
  logic                awvalid_q, wvalid_q, wlast_q, bready_q, arvalid_q, rready_q;
  logic                timeout_s;

  function automatic logic [DATA_W-1:0] beat_word(input logic [4*DATA_W-1:0] vec,
                                                  input logic [1:0] idx);
    return vec[DATA_W*int'(idx) +: DATA_W];
  endfunction

`ifdef AXI_MASTER_TIMEOUT_EN
  logic busy_s, hs_s;
  assign busy_s = (state_q == ST_AW) || (state_q == ST_W) || (state_q == ST_B) ||
                  (state_q == ST_AR) || (state_q == ST_R);
  assign hs_s   = (awvalid_q & M0_AWREADY) | (wvalid_q & M0_WREADY) | (bready_q & M0_BVALID) |
                  (arvalid_q & M0_ARREADY) | (rready_q & M0_RVALID);

  ddr_axi_wdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
    .clk_i     (ACLK),
    .rst_i     (ARESET),
    .active_i  (busy_s),
    .kick_i    (hs_s),
    .expired_o (timeout_s)
  );
`else
  assign timeout_s = 1'b0;
`endif

  // Burst sequencer: command capture, channel handshakes and completion; all outputs registered
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= ST_IDLE;
      beat_q      <= 2'd0;
      wbuf_q      <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      awaddr_q    <= '0;
      awvalid_q   <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= 4'h0;
      wlast_q     <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
    end else if (timeout_s) begin
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      wlast_q     <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_err_q   <= 1'b1;
      rsp_valid_q <= 1'b1;
      state_q     <= ST_RSP;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_ready_q && cmd_valid) begin
            cmd_ready_q <= 1'b0;
            wbuf_q      <= cmd_wdata;
            wstrb_q     <= cmd_wstrb;
            rsp_write_q <= cmd_write;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            beat_q      <= 2'd0;
            if (cmd_write) begin
              awaddr_q  <= cmd_addr & ADDR_MASK;
              awvalid_q <= 1'b1;
              state_q   <= ST_AW;
            end else begin
              araddr_q  <= cmd_addr & ADDR_MASK;
              arvalid_q <= 1'b1;
              state_q   <= ST_AR;
            end
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        ST_AW: begin
          if (M0_AWREADY) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            wdata_q   <= beat_word(wbuf_q, 2'd0);
            wlast_q   <= 1'b0;
            beat_q    <= 2'd0;
            state_q   <= ST_W;
          end
        end
        ST_W: begin
          if (M0_WREADY) begin
            if (beat_q == LAST_BEAT) begin
              wvalid_q <= 1'b0;
              wlast_q  <= 1'b0;
              bready_q <= 1'b1;
              state_q  <= ST_B;
            end else begin
              beat_q  <= beat_q + 2'd1;
              wdata_q <= beat_word(wbuf_q, beat_q + 2'd1);
              wlast_q <= ((beat_q + 2'd1) == LAST_BEAT);
            end
          end
        end
        ST_B: begin
          if (M0_BVALID) begin
            bready_q    <= 1'b0;
            rsp_err_q   <= rsp_err_q | resp_is_err(M0_BRESP);
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RSP;
          end
        end
        ST_AR: begin
          if (M0_ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            beat_q    <= 2'd0;
            state_q   <= ST_R;
          end
        end
        ST_R: begin
          if (M0_RVALID) begin
            rsp_rdata_q[DATA_W*int'(beat_q) +: DATA_W] <= M0_RDATA;
            if (resp_is_err(M0_RRESP) || (M0_RLAST != (beat_q == LAST_BEAT))) begin
              rsp_err_q <= 1'b1;
            end
            // An early RLAST terminates the burst just like the final beat does.
            if (M0_RLAST || (beat_q == LAST_BEAT)) begin
              rready_q    <= 1'b0;
              rsp_valid_q <= 1'b1;
              state_q     <= ST_RSP;
            end else begin
              beat_q <= beat_q + 2'd1;
            end
          end
        end
        ST_RSP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          cmd_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_write  = rsp_write_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign M0_AWADDR  = awaddr_q;
  assign M0_AWLEN   = AXLEN_FIXED;
  assign M0_AWVALID = awvalid_q;
  assign M0_WDATA   = wdata_q;
  assign M0_WSTRB   = wstrb_q;
  assign M0_WLAST   = wlast_q;
  assign M0_WVALID  = wvalid_q;
  assign M0_BREADY  = bready_q;
  assign M0_ARADDR  = araddr_q;
  assign M0_ARLEN   = AXLEN_FIXED;
  assign M0_ARVALID = arvalid_q;
  assign M0_RREADY  = rready_q;

endmodule

// File: tb/tb_ddr_axi_burst_master.sv
// tb_ddr_axi_burst_master: scoreboard bench with a behavioural AXI slave and a
// word-array reference model. Timeout scenario runs when AXI_MASTER_TIMEOUT_EN is defined.
module tb_ddr_axi_burst_master;
  logic         ACLK = 1'b0;
  logic         ARESET;
  logic         cmd_valid, cmd_ready, cmd_write;
  logic [31:0]  cmd_addr;
  logic [127:0] cmd_wdata;
  logic [3:0]   cmd_wstrb;
  logic         rsp_valid, rsp_ready, rsp_write, rsp_err;
  logic [127:0] rsp_rdata;
  logic [31:0]  M0_AWADDR, M0_ARADDR, M0_WDATA, M0_RDATA;
  logic [3:0]   M0_AWLEN, M0_ARLEN, M0_WSTRB;
  logic         M0_AWVALID, M0_AWREADY, M0_WLAST, M0_WVALID, M0_WREADY;
  logic [1:0]   M0_BRESP, M0_RRESP;
  logic         M0_BVALID, M0_BREADY, M0_ARVALID, M0_ARREADY, M0_RVALID, M0_RLAST, M0_RREADY;

  always #5 ACLK = ~ACLK;

  ddr_axi_burst_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .M0_AWADDR(M0_AWADDR), .M0_AWLEN(M0_AWLEN), .M0_AWVALID(M0_AWVALID), .M0_AWREADY(M0_AWREADY),
    .M0_WDATA(M0_WDATA), .M0_WSTRB(M0_WSTRB), .M0_WLAST(M0_WLAST), .M0_WVALID(M0_WVALID),
    .M0_WREADY(M0_WREADY),
    .M0_BRESP(M0_BRESP), .M0_BVALID(M0_BVALID), .M0_BREADY(M0_BREADY),
    .M0_ARADDR(M0_ARADDR), .M0_ARLEN(M0_ARLEN), .M0_ARVALID(M0_ARVALID), .M0_ARREADY(M0_ARREADY),
    .M0_RDATA(M0_RDATA), .M0_RRESP(M0_RRESP), .M0_RVALID(M0_RVALID), .M0_RLAST(M0_RLAST),
    .M0_RREADY(M0_RREADY)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always @(posedge ACLK) cyc <= cyc + 1;

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // ---------------- reference model and scoreboard ----------------
  typedef struct packed {
    logic         wr;
    logic [127:0] data;
    logic         err;
    logic         chk;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] ref_mem [int unsigned];
  logic [31:0] slv_mem [int unsigned];

  function automatic logic [31:0] ref_rd(int unsigned w);
    return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
  endfunction
  function automatic logic [31:0] slv_rd(int unsigned w);
    return slv_mem.exists(w) ? slv_mem[w] : 32'h0;
  endfunction

  // ---------------- slave configuration ----------------
  bit          rnd_ready = 1'b0;
  int          aw_stall  = 0;
  bit          w_toggle  = 1'b0;
  logic [1:0]  bresp_inj = 2'b00;
  logic [1:0]  rresp_inj = 2'b00;
  int          rlast_fault = -1;
  bit          b_suppress = 1'b0;
  bit          rsp_hold = 1'b0;

  logic [31:0]  cur_addr;
  logic [127:0] cur_wdata;
  logic [3:0]   cur_wstrb;

  // ---------------- slave state ----------------
  bit          aw_got, b_pend, r_act, aw_stalled, w_stalled;
  int          wcnt, rcnt, wlast_cyc;
  logic [31:0] w_addr, r_addr, aw_prev, w_prev;

  function automatic bit rnd_bit();
    return rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
  endfunction

  // Behavioural AXI slave plus bus-rule monitor: decide at negedge, drive at posedge+1
  initial begin
    bit r_hs;
    logic [31:0] word;
    M0_AWREADY = 1'b0; M0_WREADY = 1'b0; M0_BVALID = 1'b0; M0_BRESP = 2'b00;
    M0_ARREADY = 1'b0; M0_RVALID = 1'b0; M0_RDATA = 32'h0; M0_RRESP = 2'b00; M0_RLAST = 1'b0;
    aw_got = 0; b_pend = 0; r_act = 0; aw_stalled = 0; w_stalled = 0; wcnt = 0; rcnt = 0;
    forever begin
      @(negedge ACLK);
      r_hs = 1'b0;
      if (ARESET) begin
        aw_got = 0; b_pend = 0; r_act = 0; aw_stalled = 0; w_stalled = 0; wcnt = 0; rcnt = 0;
      end else begin
        if (aw_stalled) begin
          check("aw_hold_valid", M0_AWVALID, 1);
          check("aw_hold_addr", M0_AWADDR, aw_prev);
        end
        if (w_stalled) begin
          check("w_hold_valid", M0_WVALID, 1);
          check("w_hold_data", M0_WDATA, w_prev);
        end
        aw_stalled = M0_AWVALID && !M0_AWREADY;
        aw_prev    = M0_AWADDR;
        w_stalled  = M0_WVALID && !M0_WREADY;
        w_prev     = M0_WDATA;
        if (M0_AWVALID && !M0_AWREADY && aw_stall > 0) aw_stall--;
        if (M0_WVALID && M0_WREADY) begin
          check("w_after_aw", aw_got, 1);
          if (wcnt > 3) begin
            check("w_extra_beat", wcnt, 3);
          end else begin
            check("wdata", M0_WDATA, cur_wdata[32*wcnt +: 32]);
            check("wstrb", M0_WSTRB, cur_wstrb);
            check("wlast", M0_WLAST, (wcnt == 3));
            word = slv_rd(w_addr / 4 + wcnt);
            for (int b = 0; b < 4; b++) if (M0_WSTRB[b]) word[8*b +: 8] = M0_WDATA[8*b +: 8];
            slv_mem[w_addr / 4 + wcnt] = word;
          end
          wcnt++;
          if (M0_WLAST) begin b_pend = 1; wlast_cyc = cyc; end
        end
        if (M0_AWVALID && M0_AWREADY) begin
          check("awlen", M0_AWLEN, 4'd3);
          check("awaddr", M0_AWADDR, cur_addr);
          aw_got = 1; w_addr = M0_AWADDR; wcnt = 0;
        end
        if (M0_BVALID && M0_BREADY) begin
          check("w_beat_count", wcnt, 4);
          b_pend = 0; aw_got = 0;
        end
        if (M0_ARVALID && M0_ARREADY) begin
          check("arlen", M0_ARLEN, 4'd3);
          check("araddr", M0_ARADDR, cur_addr);
          r_act = 1; r_addr = M0_ARADDR; rcnt = 0;
        end
        if (M0_RVALID && M0_RREADY) begin
          r_hs = 1'b1;
          if (M0_RLAST) r_act = 0;
          rcnt++;
        end
      end
      @(posedge ACLK);
      #1;
      if (ARESET) begin
        M0_AWREADY = 1'b0; M0_WREADY = 1'b0; M0_BVALID = 1'b0; M0_ARREADY = 1'b0; M0_RVALID = 1'b0;
      end else begin
        M0_AWREADY = (aw_stall > 0) ? 1'b0 : rnd_bit();
        M0_WREADY  = w_toggle ? ~M0_WREADY : rnd_bit();
        M0_BVALID  = b_pend && !b_suppress;
        M0_BRESP   = M0_BVALID ? bresp_inj : 2'b00;
        M0_ARREADY = rnd_bit();
        if (!(M0_RVALID && !r_hs)) M0_RVALID = r_act ? rnd_bit() : 1'b0;
        M0_RDATA = slv_rd(r_addr / 4 + rcnt);
        M0_RRESP = rresp_inj;
        M0_RLAST = (rcnt == 3) || (rcnt == rlast_fault);
      end
    end
  end

  // Completion handshake driver
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge ACLK);
      #1;
      rsp_ready = rsp_hold ? 1'b0 : rnd_bit();
    end
  end

  // Scoreboard monitor: pops one expectation per completion handshake
  initial begin
    exp_t e;
    forever begin
      @(negedge ACLK);
      if (!ARESET && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", rsp_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_write", rsp_write, e.wr);
          check("rsp_err", rsp_err, e.err);
          if (e.chk) check("rsp_rdata", rsp_rdata, e.data);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input bit wr, input logic [31:0] addr, input logic [127:0] data,
                       input logic [3:0] strb, input bit exp_err, input bit chk, input bit track);
    exp_t e;
    int n;
    int unsigned w;
    logic [31:0] word;
    w = addr >> 2;
    cur_addr = addr & 32'hFFFF_FFFC; cur_wdata = data; cur_wstrb = strb;
    e.wr = wr; e.err = exp_err; e.chk = chk; e.data = '0;
    if (wr && track) begin
      for (int i = 0; i < 4; i++) begin
        word = ref_rd(w + i);
        for (int b = 0; b < 4; b++) if (strb[b]) word[8*b +: 8] = data[32*i + 8*b +: 8];
        ref_mem[w + i] = word;
      end
    end else if (!wr) begin
      e.data = {ref_rd(w + 3), ref_rd(w + 2), ref_rd(w + 1), ref_rd(w)};
    end
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    n = 0;
    forever begin
      @(negedge ACLK);
      if (cmd_ready) break;
      n++;
      if (n > 200) break;
    end
    if (n > 200) check("cmd_accept_timeout", cmd_ready, 1);
    else if (track) exp_q.push_back(e);
    @(posedge ACLK);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !cmd_ready) && n < 600) begin
      @(posedge ACLK);
      #1;
      n++;
    end
    if (n >= 600) begin
      check("completion_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  initial begin
    logic [127:0] d;
    logic [31:0]  a;
    bit           wr, e;
    int           n;
    ARESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0;
    cmd_wdata = '0; cmd_wstrb = 4'h0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_valids", {M0_AWVALID, M0_WVALID, M0_WLAST, M0_BREADY, M0_ARVALID, M0_RREADY}, 6'b0);
    check("rst_rsp", {rsp_valid, rsp_write, rsp_err, rsp_rdata}, '0);
    check("rst_payload", {M0_AWADDR, M0_ARADDR, M0_WDATA, M0_WSTRB}, '0);
    @(posedge ACLK); #1; ARESET = 1'b0;
    @(negedge ACLK);
    @(negedge ACLK);
    check("cmd_ready_after_rst", cmd_ready, 1);
    @(posedge ACLK); #1;

    // Directed write then read-back
    d = {32'h87654321, 32'h12345678, 32'hC0DECAFE, 32'hDEADBEEF};
    issue(1, 32'h0000, d, 4'hF, 0, 1, 1); wait_done();
    issue(0, 32'h0000, '0, 4'h0, 0, 1, 1); wait_done();

    // AWREADY stalled 5 cycles, WREADY toggling
    aw_stall = 5; w_toggle = 1;
    issue(1, 32'h0020, {32'h11112222, 32'h33334444, 32'h55556666, 32'h77778888}, 4'hF, 0, 1, 1);
    wait_done();
    w_toggle = 0; aw_stall = 0;
    issue(0, 32'h0020, '0, 4'h0, 0, 1, 1); wait_done();

    // BRESP = SLVERR, then a clean command
    bresp_inj = 2'b10;
    issue(1, 32'h0030, {4{32'hA5A5A5A5}}, 4'hF, 1, 1, 1); wait_done();
    bresp_inj = 2'b00;
    issue(0, 32'h0030, '0, 4'h0, 0, 1, 1); wait_done();

    // Early RLAST on beat 1
    rlast_fault = 1;
    issue(0, 32'h0000, '0, 4'h0, 1, 0, 1); wait_done();
    rlast_fault = -1;
    check("idle_after_rlast", cmd_ready, 1);

    // rsp_ready held low: completion must persist and no command accepted
    rsp_hold = 1;
    issue(1, 32'h0040, {32'h0BADF00D, 32'h600DCAFE, 32'h01234567, 32'h89ABCDEF}, 4'h5, 0, 1, 1);
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge ACLK); n++; end
    check("rsp_seen", rsp_valid, 1);
    repeat (5) begin
      @(posedge ACLK); #1; cmd_valid = 1'b1; cmd_write = 1'b0;
      @(negedge ACLK);
      check("rsp_held", rsp_valid, 1);
      check("busy_cmd_ready", cmd_ready, 0);
    end
    @(posedge ACLK); #1; cmd_valid = 1'b0; rsp_hold = 0;
    wait_done();
    issue(0, 32'h0040, '0, 4'h0, 0, 1, 1); wait_done();

    // Reset during W beat 2
    issue(1, 32'h2000, {4{32'hFEEDFACE}}, 4'hF, 0, 0, 0);
    n = 0;
    forever begin
      @(negedge ACLK);
      n++;
      if ((M0_WVALID && wcnt == 2) || n > 50) break;
    end
    check("w_beat2_reached", n <= 50, 1);
    ARESET = 1'b1;
    @(negedge ACLK);
    check("midrst_valids", {M0_AWVALID, M0_WVALID, M0_WLAST, M0_BREADY, M0_ARVALID, M0_RREADY}, 6'b0);
    check("midrst_rsp_valid", rsp_valid, 0);
    ARESET = 1'b0;
    @(posedge ACLK); #1;
    issue(1, 32'h1000, {32'hCAFEF00D, 32'h5EED5EED, 32'h0F0F0F0F, 32'hF0F0F0F0}, 4'hF, 0, 1, 1);
    wait_done();
    issue(0, 32'h1000, '0, 4'h0, 0, 1, 1); wait_done();

`ifdef AXI_MASTER_TIMEOUT_EN
    // BVALID never arrives: watchdog must complete with an error
    b_suppress = 1;
    issue(1, 32'h0050, {4{32'h13572468}}, 4'hF, 1, 1, 1);
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge ACLK); n++; end
    check("timeout_latency", (cyc - wlast_cyc) <= 17, 1);
    wait_done();
    b_pend = 0; b_suppress = 0;
`endif

    // Randomized traffic with random back-pressure and occasional error responses
    rnd_ready = 1;
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom_range(0, 1));
      a  = 32'h100 + ($urandom_range(0, 7) << 4) + $urandom_range(0, 3);
      d  = {$urandom, $urandom, $urandom, $urandom};
      e  = ($urandom_range(0, 7) == 0);
      if (wr) bresp_inj = e ? 2'($urandom_range(1, 3)) : 2'b00;
      else    rresp_inj = e ? 2'($urandom_range(1, 3)) : 2'b00;
      issue(wr, a, d, 4'($urandom_range(1, 15)), e, 1, 1);
      wait_done();
      bresp_inj = 2'b00; rresp_inj = 2'b00;
    end
    rnd_ready = 0;
    repeat (4) @(posedge ACLK);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ddr_axi_burst_master.md
# ddr_axi_burst_master

AXI initiator that issues fixed 4-beat INCR bursts into `ddr_axi_slave` on behalf of an internal client. It turns a single-cycle command (write: address plus 128 bits of data; read: address) into the AW/W/B or AR/R channel sequence, checks the responses, and returns one completion per command. It sits between on-chip traffic sources and the DDR AXI slave port and is the synthesizable counterpart of the bench's write/read burst procedures.

## Interface

**Parameters**
- `ADDR_W`, default 32: AXI address width.
- `DATA_W`, default 32: AXI beat width. The command data width is 4×`DATA_W`.
- `TIMEOUT_CYCLES`, default 1024: watchdog limit. Used only with `AXI_MASTER_TIMEOUT_EN`.

**Ports**
- `ACLK` in 1: single clock for all logic.
- `ARESET` in 1: synchronous, active-high reset.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake.
- `cmd_write` in 1: 1 = write burst, 0 = read burst.
- `cmd_addr` in `ADDR_W`: burst start address. Bits [1:0] are forced to 0 on the bus.
- `cmd_wdata` in 4×`DATA_W`: beat 0 is in the LSBs.
- `cmd_wstrb` in 4: byte strobe applied to all four beats.
- `rsp_valid` out 1 / `rsp_ready` in 1: completion handshake.
- `rsp_write` out 1: echoes `cmd_write`.
- `rsp_rdata` out 4×`DATA_W`: read beats, beat 0 in the LSBs. Zero for writes.
- `rsp_err` out 1: set on a SLVERR/DECERR response, an RLAST mismatch, or a timeout.
- `M0_AWADDR` out `ADDR_W`, `M0_AWLEN` out 4, `M0_AWVALID` out 1, `M0_AWREADY` in 1.
- `M0_WDATA` out `DATA_W`, `M0_WSTRB` out 4, `M0_WLAST` out 1, `M0_WVALID` out 1, `M0_WREADY` in 1.
- `M0_BRESP` in 2, `M0_BVALID` in 1, `M0_BREADY` out 1.
- `M0_ARADDR` out `ADDR_W`, `M0_ARLEN` out 4, `M0_ARVALID` out 1, `M0_ARREADY` in 1.
- `M0_RDATA` in `DATA_W`, `M0_RRESP` in 2, `M0_RVALID` in 1, `M0_RLAST` in 1, `M0_RREADY` out 1.

## Operation

**State machine:** IDLE, AW, W, B, AR, R, RSP.
- IDLE: `cmd_ready`=1. On `cmd_valid` the command is latched and the FSM moves to AW (write) or AR (read).
- AW: `M0_AWVALID`=1 until `M0_AWREADY`, then go to W.
- W: beat counter 0..3. `M0_WVALID`=1. The beat advances on `M0_WREADY`. `M0_WLAST`=1 only on beat 3. Beat 3 accepted → B.
- B: `M0_BREADY`=1. On `M0_BVALID`, capture `M0_BRESP` and go to RSP.
- AR: `M0_ARVALID`=1 until `M0_ARREADY`, then go to R.
- R: `M0_RREADY`=1. Each `M0_RVALID` stores `M0_RDATA` into slot [beat] and advances the beat.
  - `M0_RLAST` must be 1 exactly on beat 3; otherwise set the error flag.
  - On beat 3 go to RSP. An early RLAST also ends the burst and goes to RSP.
- RSP: `rsp_valid`=1 until `rsp_ready`, then return to IDLE.

**Bus rules**
- `M0_AWLEN`/`M0_ARLEN` are the constant 3.
- AW always completes before the first W beat; no write data is issued ahead of the address.
- Only one outstanding command. No overlap between read and write.
- `rsp_err` = (any RRESP≠00) OR (BRESP≠00) OR RLAST mismatch OR timeout. Sticky for the duration of the command.

## Timing
- Every output is registered.
- Reset values: `cmd_ready`=0 during reset and 1 the cycle after. All VALID, READY and LAST outputs are 0. `rsp_*` = 0. Address, data and strobe outputs are 0.
- Command accepted at edge N → AWVALID/ARVALID high after edge N.
- Each VALID holds with stable payload until its handshake edge and drops after that edge if no further beat follows.
- Back-to-back W beats run at one per cycle when WREADY is held high.
- Minimum write latency (all READYs high, BVALID one cycle after WLAST): cmd → rsp_valid in 8 cycles.
- `rsp_valid` remains asserted if `rsp_ready` is held low; no new command is accepted meanwhile.
- Reset mid-burst: at the next edge all VALIDs drop, the FSM goes to IDLE and no completion is emitted.
- `cmd_valid` asserted while busy is ignored; `cmd_ready`=0.

## Configuration
- `AXI_MASTER_TIMEOUT_EN` defined:
  - A counter resets on every handshake and counts cycles spent in AW, W, B, AR or R.
  - On reaching `TIMEOUT_CYCLES`: drop all VALID/READY outputs, set `rsp_err`=1 and go to RSP.
- Not defined: no counter; the FSM waits indefinitely; the parameter is unused.

## Structure
- Package `ddr_axi_pkg`:
  - `axi_resp_t` (OKAY=00, EXOKAY=01, SLVERR=10, DECERR=11).
  - `burst_state_t` enum.
  - `BURST_LEN`=4.
  - `AXLEN_FIXED`=4'd3.
- One sub-module, `ddr_axi_wdog`: the timeout counter. It is instantiated only under `AXI_MASTER_TIMEOUT_EN`.

## Test plan
- Write 0x0000 with {87654321,12345678,C0DECAFE,DEADBEEF}, then read 0x0000 → `rsp_rdata` matches, `rsp_err`=0, AWLEN=ARLEN=3, WLAST only on the 4th beat.
- AWREADY held low for 5 cycles and WREADY toggled every other cycle → AWADDR/WDATA stable while stalled; exactly 4 W handshakes; completion correct.
- Slave returns BRESP=10 → `rsp_err`=1, `rsp_write`=1. Next command proceeds normally.
- RLAST asserted on beat 1 → burst ends, `rsp_err`=1, FSM back to IDLE after `rsp_ready`.
- ARESET pulsed during W beat 2 → all VALIDs 0 next cycle, no `rsp_valid`; a following write to 0x1000 completes cleanly.
- With `AXI_MASTER_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, BVALID never asserted → `rsp_valid` with `rsp_err`=1 within 17 cycles of WLAST.
